// File: rtl/clk_divn_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// half_up works at 32 bits so any DIV_W up to 32 can truncate its result.
package clk_divn_pkg;
    localparam int DIV_W_DEF    = 16;
    localparam int CHANNELS_DEF = 4;
    localparam int CHAN_IDX_W   = 4;
    localparam int HU_W         = 32;

    function automatic logic [HU_W:0] half_up(input logic [HU_W-1:0] d);
        return ({1'b0, d} + (HU_W+1)'(1)) >> 1;
    endfunction
endpackage

// File: rtl/clk_divn_prog_if.sv
// Divisor write / sync controls in, divided clocks, ticks and pending flags out.
// No handshake: writes are single-cycle strobes that are always accepted.
interface clk_divn_prog_if import clk_divn_pkg::*; #(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DIV_W    = DIV_W_DEF
);
    logic                  wr_en;
    logic [CHAN_IDX_W-1:0] wr_chan;
    logic [DIV_W-1:0]      wr_div;
    logic                  sync;
    logic [CHANNELS-1:0]   clk_out;
    logic [CHANNELS-1:0]   tick;
    logic [CHANNELS-1:0]   pending;

    modport master (output wr_en, wr_chan, wr_div, sync,
                    input  clk_out, tick, pending);
    modport slave  (input  wr_en, wr_chan, wr_div, sync,
                    output clk_out, tick, pending);
endinterface

// File: rtl/clk_divn_chan.sv
// One divider channel: counter, current/pending divisor, registered clk_out/tick.
// Outputs one cycle after the causing edge; writes are never refused (deferred to the period boundary).
module clk_divn_chan import clk_divn_pkg::*; #(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic             RST_ON  = (DEFAULT_DIV != 0);

    logic [DIV_W-1:0] cnt, div_cur, div_pend;
    logic             pend_v;
    logic [DIV_W-1:0] cnt_n, div_cur_n, div_pend_n;
    logic             pend_v_n;
    logic             running, boundary;
    logic [DIV_W:0]   hi_n;
    logic             clk_out_n, tick_n;

    always_comb begin
        running    = (div_cur != '0);
        boundary   = running && (cnt == div_cur - DIV_W'(1));
        cnt_n      = cnt;
        div_cur_n  = div_cur;
        div_pend_n = div_pend;
        pend_v_n   = pend_v;

        if (running)
            cnt_n = boundary ? '0 : cnt + DIV_W'(1);

        // A stopped channel has no period to finish, so it takes the divisor at once.
        if (wr) begin
            if (running) begin
                div_pend_n = wr_div;
                pend_v_n   = 1'b1;
            end else begin
                div_cur_n = wr_div;
                cnt_n     = '0;
            end
        end

        if ((boundary || sync) && pend_v_n) begin
            div_cur_n = div_pend_n;
            pend_v_n  = 1'b0;
        end

        if (sync)
            cnt_n = '0;

        hi_n      = (DIV_W+1)'(half_up(HU_W'(div_cur_n)));
        clk_out_n = ({1'b0, cnt_n} < hi_n);
        tick_n    = (div_cur_n != '0) && (cnt_n == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            div_cur  <= RST_DIV;
            div_pend <= '0;
            pend_v   <= 1'b0;
            clk_out  <= RST_ON;
            tick     <= RST_ON;
            pending  <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            div_cur  <= div_cur_n;
            div_pend <= div_pend_n;
            pend_v   <= pend_v_n;
            clk_out  <= clk_out_n;
            tick     <= tick_n;
            pending  <= pend_v_n;
        end
    end
endmodule

// File: rtl/clk_divn_prog.sv
// Multi-channel programmable clock divider; decodes wr_chan into per-channel write strobes.
// All outputs registered one cycle after the causing edge; no backpressure, out-of-range writes are dropped.
module clk_divn_prog import clk_divn_pkg::*; #(
    parameter int CHANNELS    = CHANNELS_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 50
) (
    input  logic           clk,
    input  logic           reset,
    clk_divn_prog_if.slave bus
);
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] clk_out_v, tick_v, pending_v;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            wr_sel[i] = bus.wr_en && (bus.wr_chan == CHAN_IDX_W'(i));
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_divn_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_sel[g]),
            .wr_div  (bus.wr_div),
            .sync    (bus.sync),
            .clk_out (clk_out_v[g]),
            .tick    (tick_v[g]),
            .pending (pending_v[g])
        );
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.pending = pending_v;
endmodule

// File: tb/tb_clk_divn_prog.sv
// Directed bench for clk_divn_prog: four channels, DEFAULT_DIV = 6, phases tracked by hand-scripted updates.
module tb_clk_divn_prog;
    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    int         dm[4];
    int         ph[4];
    logic [3:0] pend_exp;

    clk_divn_prog_if #(.CHANNELS(4), .DIV_W(16)) bus ();

    clk_divn_prog #(
        .CHANNELS    (4),
        .DIV_W       (16),
        .DEFAULT_DIV (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_clk();
        logic [3:0] e;
        for (int i = 0; i < 4; i++)
            e[i] = (dm[i] != 0) && (ph[i] < (dm[i] + 1) / 2);
        return e;
    endfunction

    function automatic logic [3:0] exp_tick();
        logic [3:0] e;
        for (int i = 0; i < 4; i++)
            e[i] = (dm[i] != 0) && (ph[i] == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        check({tag, ".clk_out"}, bus.clk_out, exp_clk());
        check({tag, ".tick"},    bus.tick,    exp_tick());
        check({tag, ".pending"}, bus.pending, pend_exp);
    endtask

    // One clock edge; phases advance with the divisor in force before the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (dm[i] != 0)
                ph[i] = (ph[i] + 1 == dm[i]) ? 0 : ph[i] + 1;
    endtask

    task automatic wr(input int ch, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_chan = 4'(ch);
        bus.wr_div  = 16'(d);
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            dm[i] = 6;
            ph[i] = 0;
        end
        pend_exp = 4'b0000;
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_chan = '0;
        bus.wr_div  = '0;
        bus.sync    = 1'b0;
        model_reset();

        // Reset values, then release: first tick coincides with release.
        #12;
        check("rst.clk_out", bus.clk_out, 4'b1111);
        check("rst.tick",    bus.tick,    4'b1111);
        check("rst.pending", bus.pending, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all("release");
        for (int k = 0; k < 24; k++) begin
            step();
            chk_all("d6");
        end

        // ch1 := 5 written mid-period, deferred to the boundary.
        step(); chk_all("pre_w5");
        step(); chk_all("pre_w5");
        wr(1, 5);
        step(); idle();
        pend_exp = 4'b0010;
        chk_all("w5_pend");
        step(); chk_all("w5_pend");
        step(); chk_all("w5_pend");
        step();
        dm[1] = 5;
        pend_exp = 4'b0000;
        chk_all("w5_apply");
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all("d5");
        end

        // ch2 stopped by writing 0, then restarted with 7.
        wr(2, 0);
        step(); idle();
        pend_exp = 4'b0100;
        chk_all("w0_pend");
        step();
        dm[2] = 0;
        pend_exp = 4'b0000;
        chk_all("w0_stop");
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("stopped");
        end
        wr(2, 7);
        step(); idle();
        dm[2] = 7;
        ph[2] = 0;
        chk_all("w7_start");
        for (int k = 0; k < 7; k++) begin
            step();
            chk_all("d7");
        end

        // Align, load 3/4/1/9 as pending, then sync (ch1 also at its boundary then).
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        for (int i = 0; i < 4; i++) ph[i] = 0;
        chk_all("sync0");
        wr(0, 3); step(); pend_exp = 4'b0001; chk_all("ld3");
        wr(1, 4); step(); pend_exp = 4'b0011; chk_all("ld4");
        wr(2, 1); step(); pend_exp = 4'b0111; chk_all("ld1");
        wr(3, 9); step(); idle(); pend_exp = 4'b1111; chk_all("ld9");
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        dm[0] = 3; dm[1] = 4; dm[2] = 1; dm[3] = 9;
        for (int i = 0; i < 4; i++) ph[i] = 0;
        pend_exp = 4'b0000;
        check("sync1.tick_all", bus.tick, 4'b1111);
        chk_all("sync1");
        for (int k = 0; k < 9; k++) begin
            step();
            chk_all("mix");
        end

        // Write on ch0's boundary cycle, back-to-back 8/10 on ch3, out-of-range channel.
        step(); chk_all("pre_bw");
        step(); chk_all("pre_bw");
        wr(0, 5);
        step();
        dm[0] = 5;
        chk_all("bnd_write");
        wr(3, 8);
        step(); pend_exp = 4'b1000; chk_all("w8");
        wr(3, 10);
        step(); chk_all("w10");
        wr(15, 2);
        step(); idle(); chk_all("w15");
        step(); chk_all("wait_bnd");
        step(); chk_all("wait_bnd");
        step();
        dm[3] = 10;
        pend_exp = 4'b0000;
        chk_all("w10_apply");
        for (int k = 0; k < 10; k++) begin
            step();
            chk_all("d10");
        end

        // Asynchronous reset while ch1 holds a pending divisor.
        wr(1, 7);
        step(); idle();
        pend_exp = 4'b0010;
        chk_all("pre_arst");
        #1;
        reset = 1'b1;
        #2;
        check("arst.clk_out", bus.clk_out, 4'b1111);
        check("arst.tick",    bus.tick,    4'b1111);
        check("arst.pending", bus.pending, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk_all("arst_rel");
        for (int k = 0; k < 6; k++) begin
            step();
            chk_all("arst_d6");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_divn_prog.md
# clk_divn_prog

Multi-channel, runtime-programmable integer clock divider. It produces, per channel, a registered divided clock (`clk_out`) and a one-cycle period-start strobe (`tick`) from a single system clock. Divisors can be rewritten at any time and take effect glitch-free at the next period boundary. A global `sync` re-aligns all channels. It supersedes fixed-parameter dividers wherever several peripheral rates (baud, timer, video/audio enables) derive from one clock.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `DIV_W`, 16: divisor/counter width in bits; max divisor 2^DIV_W-1.
- `DEFAULT_DIV`, 50: divisor loaded into every channel at reset; 0 = channel stopped.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: divisor write strobe.
- `wr_chan` in 4: target channel of write; values ≥ CHANNELS ignored.
- `wr_div` in DIV_W: divisor to write; 0 stops the channel.
- `sync` in 1: restart all channels at count 0 in the next cycle.
- `clk_out` out CHANNELS: divided clocks, registered.
- `tick` out CHANNELS: one-cycle strobe at each period start, registered.
- `pending` out CHANNELS: channel holds a written divisor not yet applied.

## Operation
- Per-channel state: `cnt` (DIV_W), `div_cur` (DIV_W), `div_pend` (DIV_W), `pend_v`.
- Running means `div_cur ≠ 0`. Period = `div_cur` cycles, with `cnt` going 0..div_cur-1.
- `clk_out` is high while `cnt < hi`, where `hi = (div_cur+1)>>1` is computed in DIV_W+1 bits. High for ceil(D/2) cycles, low for floor(D/2). Even D gives 50% duty; odd D is high one cycle longer.
- `tick` is high exactly in the cycle where `cnt == 0` and the channel is running, so it coincides with the `clk_out` rising edge.
- Boundary (`cnt == div_cur-1`):
  - `cnt` goes to 0.
  - If `pend_v`, then `div_cur` takes `div_pend` and `pend_v` clears.
- Write to a running channel: `div_pend` takes `wr_div` and `pend_v` sets.
  - A write in the same cycle as that channel's boundary is applied at that boundary.
  - Several writes before a boundary: last one wins.
- Write to a stopped channel: applied immediately; `cnt` goes to 0 and `pend_v` stays 0.
- Writing 0 to a running channel stops it at the next boundary. After that, `cnt` holds 0, `clk_out` is 0 and `tick` is 0.
- D = 1: `clk_out` and `tick` are held constantly high.
- `sync`:
  - Every channel's `cnt` goes to 0.
  - Any pending divisor, including one written in the same cycle, is applied and `pend_v` clears.
  - Stopped channels stay stopped unless written.
- `sync` and a boundary in the same cycle behave identically to `sync` alone.

## Timing
- Outputs are computed from next-state values and registered. There is no combinational path from any input to any output.
- Reset values:
  - `cnt` = 0, `div_cur` = DEFAULT_DIV, `pend_v` = 0.
  - `clk_out` = `tick` = (DEFAULT_DIV ≠ 0).
  - `pending` = 0.
- First post-reset edge: `cnt` = 1, or stays 0 if DEFAULT_DIV ≤ 1.
- Write latency:
  - `pending` rises the cycle after `wr_en`.
  - The new period starts, with `tick` high, the cycle after the boundary.
  - For a stopped channel, `tick` is high the cycle after `wr_en`.
- `sync` latency: all running channels show `cnt` = 0 and `tick` = 1 in the cycle after `sync`.
- Reset mid-operation clears everything asynchronously, with no partial period completed. Pending writes are lost.
- Counter wrap: `cnt` never exceeds `div_cur-1`. A divisor decreased mid-period does not truncate the current period because it is deferred.

## Structure
- Package `clk_divn_pkg`:
  - Default `DIV_W` and `CHANNELS` constants.
  - Function `half_up(d)` returning `(d+1)>>1` in DIV_W+1 bits.
  - Channel-index width constant.
- Sub-module `clk_divn_chan`: one channel, holding the counter, divisor registers, boundary logic and output registers. Inputs are a local write strobe, `wr_div` and `sync`.
- Top `clk_divn_prog` decodes `wr_chan` into per-channel write strobes and generate-instantiates CHANNELS copies of the sub-module.

## Test plan
- Reset with DEFAULT_DIV = 6, then run 24 cycles → each `clk_out` is 3 high / 3 low; `tick` is high every 6th cycle, first at reset release; `pending` = 0.
- Write D = 5 to ch1 mid-period of D = 6 → ch1 `pending` = 1 until the boundary. The next period is 3 high / 2 low with 5-cycle `tick` spacing. Other channels are unaffected.
- Write 0 to ch2, then later write 7 → ch2 stops at its boundary with `clk_out` = 0 and `tick` = 0. After the write of 7, `tick` is high the next cycle, then 4 high / 3 low.
- Channels at D = 3, 4, 1, 9 with `sync` asserted at an arbitrary cycle → the next cycle all `tick` bits are 1 and each channel restarts with `cnt` = 0. The D = 1 channel stays constantly high.
- Write on the boundary cycle, plus two back-to-back writes (8 then 10), plus `wr_chan` = 15 → the boundary write is applied at once; 10 wins over 8; the out-of-range write changes nothing.
- Assert `reset` mid-period with `pending` set → outputs immediately return to reset values, `pending` = 0, and the DEFAULT_DIV period restarts.
